op_scheduler: RTL and testbench

Queues region-update operations written over the SPI control/status registers. Each operation is a command, a parameter and a rectangle (left/right/top/bottom). Operations are dispatched one at a time, aligned to frame boundaries, and each is held active for a latched number of waveform frames. The block sits between the CSR block's op strobe and the pixel-processing/update engine, and returns status for CSR readback.

---
 rtl/op_scheduler_pkg.sv | 32 +++
 rtl/op_scheduler_fifo.sv | 68 ++++++
 rtl/op_scheduler.sv | 178 +++++++++++++++++
 tb/tb_op_scheduler.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/op_scheduler_pkg.sv
// Shared types and constants for the op scheduler: command codes, FSM states
// and the queued-entry layout (8+8+4*12+6 = 70 bits).
package op_scheduler_pkg;

  localparam int unsigned CMD_W    = 8;
  localparam int unsigned PARAM_W  = 8;
  localparam int unsigned COORD_W  = 12;
  localparam int unsigned FRAMES_W = 6;

  localparam logic [CMD_W-1:0] CMD_ABORT = 8'hFF;

  typedef enum logic {
    SCH_IDLE = 1'b0,
    SCH_RUN  = 1'b1
  } sch_state_e;

  typedef struct packed {
    logic [CMD_W-1:0]    cmd;
    logic [PARAM_W-1:0]  param;
    logic [COORD_W-1:0]  left;
    logic [COORD_W-1:0]  right;
    logic [COORD_W-1:0]  top;
    logic [COORD_W-1:0]  bottom;
    logic [FRAMES_W-1:0] frames;
  } op_entry_t;

  // A zero frame count still applies the op for one frame.
  function automatic logic [FRAMES_W-1:0] frames_min1(input logic [FRAMES_W-1:0] f);
    return (f == '0) ? FRAMES_W'(1) : f;
  endfunction

endpackage

// File: rtl/op_scheduler_fifo.sv
// Synchronous DEPTH-entry FIFO of op entries with head data presented
// combinationally; flush empties it in one cycle.
module op_scheduler_fifo
  import op_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  op_entry_t                din,
  output op_entry_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  op_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rptr_q];
  assign do_push = push && (!full || pop) && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PW'(1);
      if (do_pop)  rptr_d = rptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/op_scheduler.sv
// Queues CSR region-update ops and dispatches them one at a time on frame
// boundaries. Define OP_SCHED_CLAMP_EN to clamp rectangles to the panel at push.
module op_scheduler
  import op_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned H_RES = 1600,
  parameter int unsigned V_RES = 1200
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [CMD_W-1:0]        in_cmd,
  input  logic [PARAM_W-1:0]      in_param,
  input  logic [COORD_W-1:0]      in_left,
  input  logic [COORD_W-1:0]      in_right,
  input  logic [COORD_W-1:0]      in_top,
  input  logic [COORD_W-1:0]      in_bottom,
  input  logic [FRAMES_W-1:0]     in_frames,
  input  logic                    frame_start,
  output logic                    op_active,
  output logic                    op_start,
  output logic                    op_done,
  output logic [CMD_W-1:0]        op_cmd,
  output logic [PARAM_W-1:0]      op_param,
  output logic [COORD_W-1:0]      op_left,
  output logic [COORD_W-1:0]      op_right,
  output logic [COORD_W-1:0]      op_top,
  output logic [COORD_W-1:0]      op_bottom,
  output logic [FRAMES_W-1:0]     op_frame_idx,
  output logic [$clog2(DEPTH):0]  st_count,
  output logic                    st_overflow,
  output logic                    st_badrect,
  input  logic                    st_clr
);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
      H_RES < 1 || H_RES > 4096 || V_RES < 1 || V_RES > 4096) begin : g_bad_param
    $error("op_scheduler: unsupported DEPTH/H_RES/V_RES");
  end

  sch_state_e          state_q, state_d;
  op_entry_t           cur_q, cur_d;
  logic [FRAMES_W-1:0] idx_q, idx_d;
  logic                active_q, active_d;
  logic                start_q, start_d;
  logic                done_q, done_d;
  logic                pend_q, pend_d;
  logic                ovf_q, ovf_d;
  logic                bad_q, bad_d;

  op_entry_t           entry_c, head;
  logic                bad_rect_c, abort_now, last_frame_c, pop_c, push_c;
  logic                fifo_full, fifo_empty;

  // Build the entry to queue; frame count is latched here.
  always_comb begin
    entry_c.cmd    = in_cmd;
    entry_c.param  = in_param;
    entry_c.left   = in_left;
    entry_c.right  = in_right;
    entry_c.top    = in_top;
    entry_c.bottom = in_bottom;
    entry_c.frames = frames_min1(in_frames);
    bad_rect_c     = (in_left > in_right) || (in_top > in_bottom);
`ifdef OP_SCHED_CLAMP_EN
    if (in_right > COORD_W'(H_RES - 1))  entry_c.right  = COORD_W'(H_RES - 1);
    if (in_bottom > COORD_W'(V_RES - 1)) entry_c.bottom = COORD_W'(V_RES - 1);
    bad_rect_c = (in_left > entry_c.right) || (in_top > entry_c.bottom) ||
                 (in_left > COORD_W'(H_RES - 1)) || (in_top > COORD_W'(V_RES - 1));
`endif
  end

  assign abort_now    = in_valid && (in_cmd == CMD_ABORT);
  assign last_frame_c = (idx_q == cur_q.frames - FRAMES_W'(1));
  assign pop_c  = frame_start && !fifo_empty && !abort_now &&
                  ((state_q == SCH_IDLE) || (!pend_q && last_frame_c));
  assign push_c = in_valid && !abort_now && !bad_rect_c && (!fifo_full || pop_c);

  op_scheduler_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .flush (abort_now),
    .din   (entry_c),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (st_count)
  );

  // Next state, registered outputs and sticky status.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    idx_d    = idx_q;
    active_d = active_q;
    start_d  = 1'b0;
    done_d   = 1'b0;
    pend_d   = pend_q;
    ovf_d    = st_clr ? 1'b0 : ovf_q;
    bad_d    = st_clr ? 1'b0 : bad_q;
    if (in_valid && !abort_now && bad_rect_c)                              bad_d = 1'b1;
    if (in_valid && !abort_now && !bad_rect_c && fifo_full && !pop_c)     ovf_d = 1'b1;

    case (state_q)
      SCH_IDLE: begin
        pend_d = 1'b0;
        if (pop_c) begin
          cur_d    = head;
          idx_d    = '0;
          active_d = 1'b1;
          start_d  = 1'b1;
          state_d  = SCH_RUN;
        end
      end
      SCH_RUN: begin
        if (abort_now) pend_d = 1'b1;
        if (frame_start) begin
          if (pend_q || last_frame_c) begin
            done_d = 1'b1;
            pend_d = 1'b0;
            if (pop_c) begin
              cur_d   = head;
              idx_d   = '0;
              start_d = 1'b1;
            end else begin
              active_d = 1'b0;
              state_d  = SCH_IDLE;
            end
          end else begin
            idx_d = idx_q + FRAMES_W'(1);
          end
        end
      end
      default: state_d = SCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SCH_IDLE;
      cur_q    <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      pend_q   <= 1'b0;
      ovf_q    <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      idx_q    <= idx_d;
      active_q <= active_d;
      start_q  <= start_d;
      done_q   <= done_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      bad_q    <= bad_d;
    end
  end

  assign op_active    = active_q;
  assign op_start     = start_q;
  assign op_done      = done_q;
  assign op_cmd       = cur_q.cmd;
  assign op_param     = cur_q.param;
  assign op_left      = cur_q.left;
  assign op_right     = cur_q.right;
  assign op_top       = cur_q.top;
  assign op_bottom    = cur_q.bottom;
  assign op_frame_idx = idx_q;
  assign st_overflow  = ovf_q;
  assign st_badrect   = bad_q;

endmodule

// File: tb/tb_op_scheduler.sv
// Directed bench for op_scheduler: dispatch timing, back-to-back ops, overflow,
// bad rectangles, abort, reset mid-op and the optional clamp.
module tb_op_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_cmd, in_param;
  logic [11:0] in_left, in_right, in_top, in_bottom;
  logic [5:0]  in_frames;
  logic        frame_start;
  logic        op_active, op_start, op_done;
  logic [7:0]  op_cmd, op_param;
  logic [11:0] op_left, op_right, op_top, op_bottom;
  logic [5:0]  op_frame_idx;
  logic [2:0]  st_count;
  logic        st_overflow, st_badrect, st_clr;

  int vectors = 0;
  int miscompares = 0;

  op_scheduler #(.DEPTH(4), .H_RES(1600), .V_RES(1200)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_cmd(in_cmd), .in_param(in_param),
    .in_left(in_left), .in_right(in_right), .in_top(in_top), .in_bottom(in_bottom),
    .in_frames(in_frames), .frame_start(frame_start),
    .op_active(op_active), .op_start(op_start), .op_done(op_done),
    .op_cmd(op_cmd), .op_param(op_param),
    .op_left(op_left), .op_right(op_right), .op_top(op_top), .op_bottom(op_bottom),
    .op_frame_idx(op_frame_idx), .st_count(st_count),
    .st_overflow(st_overflow), .st_badrect(st_badrect), .st_clr(st_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_op(input logic [7:0] cmd, input logic [11:0] l, r, t, b,
                        input logic [5:0] f);
    in_cmd = cmd; in_param = cmd ^ 8'h5A;
    in_left = l; in_right = r; in_top = t; in_bottom = b; in_frames = f;
  endtask

  // One-cycle op strobe; inputs change and outputs are sampled on negedges.
  task automatic push(input logic [7:0] cmd, input logic [11:0] l, r, t, b,
                      input logic [5:0] f);
    set_op(cmd, l, r, t, b, f);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_frames = 6'd0;
  endtask

  task automatic fs();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; frame_start = 1'b0; st_clr = 1'b0;
    set_op(8'h00, 12'd0, 12'd0, 12'd0, 12'd0, 6'd0);
    repeat (3) @(negedge clk);
    chk("rst_active", op_active, 0);
    chk("rst_count", st_count, 0);
    chk("rst_cmd", op_cmd, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single op of 3 frames
    push(8'h01, 12'd0, 12'd99, 12'd0, 12'd49, 6'd3);
    chk("t1_count_q", st_count, 1);
    fs();
    chk("t1_start", op_start, 1);
    chk("t1_active", op_active, 1);
    chk("t1_idx0", op_frame_idx, 0);
    chk("t1_right", op_right, 99);
    chk("t1_bottom", op_bottom, 49);
    chk("t1_count_run", st_count, 0);
    @(negedge clk);
    chk("t1_start_pulse", op_start, 0);
    fs();
    chk("t1_idx1", op_frame_idx, 1);
    fs();
    chk("t1_idx2", op_frame_idx, 2);
    chk("t1_no_done", op_done, 0);
    fs();
    chk("t1_done", op_done, 1);
    chk("t1_idle", op_active, 0);
    chk("t1_no_start", op_start, 0);
    @(negedge clk);
    chk("t1_done_pulse", op_done, 0);
    chk("t1_hold_right", op_right, 99);

    // Overflow and sticky clear
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i), 12'd0, 12'd1, 12'd0, 12'd1, 6'd1);
    chk("t2_count_full", st_count, 4);
    chk("t2_ovf", st_overflow, 1);
    st_clr = 1'b1; @(negedge clk); st_clr = 1'b0;
    chk("t2_ovf_clr", st_overflow, 0);
    chk("t2_count_kept", st_count, 4);
    push(8'hFF, 12'd0, 12'd0, 12'd0, 12'd0, 6'd0);
    chk("t2_flush_idle", st_count, 0);
    fs();
    chk("t2_empty_fs_start", op_start, 0);
    chk("t2_empty_fs_active", op_active, 0);

    // Back-to-back ops A (2 frames) then B (1 frame)
    push(8'hA1, 12'd1, 12'd2, 12'd3, 12'd4, 6'd2);
    push(8'hB2, 12'd5, 12'd6, 12'd7, 12'd8, 6'd1);
    fs();
    chk("t3_a_start", op_start, 1);
    chk("t3_a_cmd", op_cmd, 8'hA1);
    chk("t3_a_param", op_param, 8'hFB);
    fs();
    chk("t3_a_idx1", op_frame_idx, 1);
    chk("t3_a_no_done", op_done, 0);
    fs();
    chk("t3_ab_done", op_done, 1);
    chk("t3_ab_start", op_start, 1);
    chk("t3_b_cmd", op_cmd, 8'hB2);
    chk("t3_b_left", op_left, 5);
    chk("t3_b_top", op_top, 7);
    chk("t3_b_idx0", op_frame_idx, 0);
    chk("t3_b_active", op_active, 1);
    fs();
    chk("t3_b_done", op_done, 1);
    chk("t3_b_no_start", op_start, 0);
    chk("t3_b_idle", op_active, 0);

    // Bad rectangle, clear collision, zero frame count
    push(8'h20, 12'd200, 12'd100, 12'd0, 12'd1, 6'd1);
    chk("t4_bad", st_badrect, 1);
    chk("t4_bad_count", st_count, 0);
    st_clr = 1'b1;
    push(8'h21, 12'd0, 12'd1, 12'd9, 12'd8, 6'd1);
    st_clr = 1'b0;
    chk("t4_err_wins", st_badrect, 1);
    st_clr = 1'b1; @(negedge clk); st_clr = 1'b0;
    chk("t4_bad_clr", st_badrect, 0);
    push(8'h33, 12'd0, 12'd0, 12'd0, 12'd0, 6'd0);
    fs();
    chk("t4_f0_start", op_start, 1);
    chk("t4_f0_cmd", op_cmd, 8'h33);
    fs();
    chk("t4_f0_done", op_done, 1);
    chk("t4_f0_idle", op_active, 0);

    // Abort while running with two queued
    push(8'h41, 12'd0, 12'd1, 12'd0, 12'd1, 6'd5);
    push(8'h42, 12'd0, 12'd1, 12'd0, 12'd1, 6'd1);
    push(8'h43, 12'd0, 12'd1, 12'd0, 12'd1, 6'd1);
    fs();
    chk("t5_cmd", op_cmd, 8'h41);
    chk("t5_count", st_count, 2);
    push(8'hFF, 12'd0, 12'd0, 12'd0, 12'd0, 6'd0);
    chk("t5_flush", st_count, 0);
    chk("t5_still_active", op_active, 1);
    chk("t5_no_early_done", op_done, 0);
    fs();
    chk("t5_abort_done", op_done, 1);
    chk("t5_abort_idle", op_active, 0);
    chk("t5_abort_no_start", op_start, 0);
    fs();
    chk("t5_after_active", op_active, 0);

    // Push coincident with frame_start while idle and empty: no bypass
    set_op(8'h51, 12'd0, 12'd1, 12'd0, 12'd1, 6'd1);
    in_valid = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; frame_start = 1'b0;
    chk("t6_count", st_count, 1);
    chk("t6_no_bypass", op_active, 0);
    fs();
    chk("t6_start", op_start, 1);
    chk("t6_cmd", op_cmd, 8'h51);
    fs();
    chk("t6_done", op_done, 1);

    // Push and pop in the same cycle while full
    for (int i = 0; i < 4; i++) push(8'h60 + 8'(i), 12'd0, 12'd1, 12'd0, 12'd1, 6'd2);
    chk("t7_full", st_count, 4);
    set_op(8'h64, 12'd0, 12'd1, 12'd0, 12'd1, 6'd2);
    in_valid = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; frame_start = 1'b0;
    chk("t7_count_same", st_count, 4);
    chk("t7_start", op_start, 1);
    chk("t7_cmd", op_cmd, 8'h60);
    chk("t7_no_ovf", st_overflow, 0);

    // Reset mid-run with queued ops
    rst = 1'b1;
    @(negedge clk);
    chk("t8_active", op_active, 0);
    chk("t8_done", op_done, 0);
    chk("t8_count", st_count, 0);
    chk("t8_cmd", op_cmd, 0);
    chk("t8_idx", op_frame_idx, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t8_no_done_after", op_done, 0);

    // Right edge past the panel width
    push(8'h70, 12'd10, 12'd2000, 12'd0, 12'd1199, 6'd1);
    fs();
    chk("t9_start", op_start, 1);
`ifdef OP_SCHED_CLAMP_EN
    chk("t9_right", op_right, 1599);
`else
    chk("t9_right", op_right, 2000);
`endif
    chk("t9_bottom", op_bottom, 1199);
    fs();
    chk("t9_done", op_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
